// File: rtl/pc_fetch_gen.sv
// Fetch-stage program counter with prioritised redirects (exc > eret > br), pending-redirect latch
// and misaligned-fetch trap. Optional macro PC_REDIRECT_CNT_EN adds a saturating redirect counter.
module pc_fetch_gen #(
    parameter int unsigned WIDTH      = 32,
    parameter logic [31:0] RESET_VEC  = 32'hBFC00000,
    parameter int unsigned STEP       = 4,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_target,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] eret_target,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    output logic [WIDTH-1:0] pc,
    output logic             adel,
`ifdef PC_REDIRECT_CNT_EN
    output logic [31:0]      redirect_cnt,
`endif
    output logic [1:0]       state_dbg
);

    // Handshake: inst_req/inst_addr form a valid, inst_addr_ok is ready; a request is
    // accepted on a cycle where both are high, and until then inst_req and inst_addr hold.

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] RST_PC     = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic [1:0]       pend_prio_q, pend_prio_d;
    logic             adel_q, adel_d;
    logic             wait_q, wait_d;

    logic             sel_valid;
    logic [WIDTH-1:0] sel_target;
    logic [1:0]       sel_prio;
    logic             misaligned;
    logic             fire;

    always_comb begin
        sel_valid  = exc_valid | eret_valid | br_valid;
        sel_target = br_target;
        sel_prio   = br_valid ? 2'd1 : 2'd0;
        if (exc_valid) begin
            sel_target = exc_target;
            sel_prio   = 2'd3;
        end else if (eret_valid) begin
            sel_target = eret_target;
            sel_prio   = 2'd2;
        end
    end

    assign misaligned = (pc_q & ALIGN_MASK) != '0;
    assign fire       = inst_req & inst_addr_ok;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_prio_d   = pend_prio_q;
        adel_d        = adel_q;
        wait_d        = wait_q;
        inst_req      = 1'b0;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                // An outstanding request ignores stall so the address stays committed.
                inst_req = !misaligned && (wait_q || !stall);
                if (inst_req && inst_addr_ok) begin
                    wait_d       = 1'b0;
                    pend_valid_d = 1'b0;
                    if (sel_valid) begin
                        pc_d = sel_target;
                    end else if (pend_valid_q) begin
                        pc_d = pend_target_q;
                    end else begin
                        pc_d = pc_q + STEP_W;
                    end
                end else if (inst_req) begin
                    wait_d = 1'b1;
                    if (sel_valid && (!pend_valid_q || sel_prio >= pend_prio_q)) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = sel_target;
                        pend_prio_d   = sel_prio;
                    end
                end else if (sel_valid) begin
                    pc_d         = sel_target;
                    pend_valid_d = 1'b0;
                end else if (pend_valid_q) begin
                    pc_d         = pend_target_q;
                    pend_valid_d = 1'b0;
                end else if (misaligned) begin
                    adel_d  = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (exc_valid) begin
                    pc_d         = exc_target;
                    adel_d       = 1'b0;
                    pend_valid_d = 1'b0;
                    state_d      = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RST_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_prio_q   <= 2'd0;
            adel_q        <= 1'b0;
            wait_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_prio_q   <= pend_prio_d;
            adel_q        <= adel_d;
            wait_q        <= wait_d;
        end
    end

    assign inst_addr = pc_q;
    assign pc        = pc_q;
    assign adel      = adel_q;
    assign state_dbg = state_q;

`ifdef PC_REDIRECT_CNT_EN
    logic        redirect_apply;
    logic [31:0] cnt_q, cnt_d;

    // In RUN a redirect lands on pc either on acceptance or while no request is up.
    always_comb begin
        redirect_apply = 1'b0;
        if (state_q == S_RUN) begin
            redirect_apply = (fire || !inst_req) && (sel_valid || pend_valid_q);
        end else if (state_q == S_ERR) begin
            redirect_apply = exc_valid;
        end
        cnt_d = cnt_q;
        if (redirect_apply && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign redirect_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen: a cycle-level reference model checked every negedge,
// plus hand-computed expectations along the directed sequence.
module tb_pc_fetch_gen;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  logic stall, exc_valid, eret_valid, br_valid, inst_addr_ok;
  logic [W-1:0] exc_target, eret_target, br_target;
  logic inst_req, adel;
  logic [W-1:0] inst_addr, pc;
  logic [1:0] state_dbg;
`ifdef PC_REDIRECT_CNT_EN
  logic [31:0] redirect_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;

  pc_fetch_gen dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .exc_valid(exc_valid),
    .exc_target(exc_target),
    .eret_valid(eret_valid),
    .eret_target(eret_target),
    .br_valid(br_valid),
    .br_target(br_target),
    .inst_req(inst_req),
    .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .pc(pc),
    .adel(adel),
`ifdef PC_REDIRECT_CNT_EN
    .redirect_cnt(redirect_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: mode 0 idle-after-reset, 1 fetching, 2 address-error trap
  int           m_mode;
  logic [W-1:0] m_pc, m_pend_t;
  bit           m_pend, m_wait, m_adel;
  int           m_pend_p;
  longint       m_cnt;

  function automatic bit m_req();
    return (m_mode == 1) && (m_pc % 4 == 0) && (m_wait || !stall);
  endfunction

  task automatic model_step();
    bit sv, req, fire, applied;
    logic [W-1:0] st;
    int sp;
    sv = 1; st = '0; sp = 0; applied = 0;
    if (exc_valid) begin st = exc_target; sp = 3; end
    else if (eret_valid) begin st = eret_target; sp = 2; end
    else if (br_valid) begin st = br_target; sp = 1; end
    else sv = 0;
    req = m_req();
    fire = req && inst_addr_ok;
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (fire) begin
          m_wait = 0;
          if (sv) begin m_pc = st; applied = 1; end
          else if (m_pend) begin m_pc = m_pend_t; applied = 1; end
          else m_pc = m_pc + 4;
          m_pend = 0;
        end else if (req) begin
          m_wait = 1;
          if (sv && (!m_pend || sp >= m_pend_p)) begin
            m_pend = 1; m_pend_t = st; m_pend_p = sp;
          end
        end else if (sv) begin
          m_pc = st; m_pend = 0; applied = 1;
        end else if (m_pend) begin
          m_pc = m_pend_t; m_pend = 0; applied = 1;
        end else if (m_pc % 4 != 0) begin
          m_adel = 1; m_mode = 2;
        end
      end
      default: begin
        if (exc_valid) begin
          m_pc = exc_target; m_adel = 0; m_mode = 1; applied = 1;
        end
      end
    endcase
    if (applied && m_cnt < 64'hFFFF_FFFF) m_cnt++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pc = 32'hBFC0_0000; m_pend = 0; m_pend_t = '0;
      m_pend_p = 0; m_wait = 0; m_adel = 0; m_cnt = 0;
    end else begin
      model_step();
    end
  end

  // compare process
  always @(negedge clk) begin
    check("inst_req", inst_req, m_req());
    check("inst_addr", inst_addr, m_pc);
    check("pc", pc, m_pc);
    check("adel", adel, m_adel);
`ifdef PC_REDIRECT_CNT_EN
    check("redirect_cnt", redirect_cnt, m_cnt);
`endif
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  initial begin
    rst = 1; stall = 0; exc_valid = 0; eret_valid = 0; br_valid = 0;
    exc_target = '0; eret_target = '0; br_target = '0; inst_addr_ok = 1;
    repeat (2) @(negedge clk);
    #2;
    rst = 0;

    // 1: boot idle cycle then sequential fetch
    check("t1_pc_reset", pc, 32'hBFC0_0000);
    check("t1_req_boot", inst_req, 1'b0);
    check("t1_state_boot", state_dbg, 2'd0);
    step();
    check("t1_req_run", inst_req, 1'b1);
    check("t1_addr0", inst_addr, 32'hBFC0_0000);
    step();
    check("t1_addr1", inst_addr, 32'hBFC0_0004);
    step();
    check("t1_addr2", inst_addr, 32'hBFC0_0008);
    step();
    step();
    check("t1_addr4", inst_addr, 32'hBFC0_0010);

    // 2: held request, branch latched as pending, stall ignored while waiting
    inst_addr_ok = 0;
    step();
    check("t2_hold0", inst_addr, 32'hBFC0_0010);
    br_valid = 1; br_target = 32'h8000_1000; stall = 1;
    step();
    br_valid = 0;
    check("t2_hold1", inst_addr, 32'hBFC0_0010);
    check("t2_req_stalled", inst_req, 1'b1);
    step();
    check("t2_hold2", inst_addr, 32'hBFC0_0010);
    inst_addr_ok = 1; stall = 0;
    check("t2_req_accept", inst_req, 1'b1);
    step();
    check("t2_pending_applied", pc, 32'h8000_1000);

    // 3: exception beats branch in the same cycle
    exc_valid = 1; exc_target = 32'hBFC0_0380; br_valid = 1; br_target = 32'h8000_2000;
    step();
    exc_valid = 0; br_valid = 0;
    check("t3_exc_wins", pc, 32'hBFC0_0380);

    // 4: misaligned eret target traps, only exception leaves the trap
    eret_valid = 1; eret_target = 32'h8000_0003;
    step();
    eret_valid = 0;
    check("t4_pc_mis", pc, 32'h8000_0003);
    check("t4_no_req", inst_req, 1'b0);
    step();
    check("t4_adel", adel, 1'b1);
    check("t4_state_err", state_dbg, 2'd2);
    br_valid = 1; br_target = 32'h8000_2000;
    step();
    br_valid = 0;
    check("t4_br_ignored", pc, 32'h8000_0003);
    exc_valid = 1; exc_target = 32'hBFC0_0380;
    step();
    exc_valid = 0;
    check("t4_exc_pc", pc, 32'hBFC0_0380);
    check("t4_adel_clr", adel, 1'b0);
    check("t4_req_resume", inst_req, 1'b1);
    step();
    check("t4_seq", pc, 32'hBFC0_0384);

    // 5: wrap at the top of the address space, async reset mid-wait
    br_valid = 1; br_target = 32'hFFFF_FFFC;
    step();
    br_valid = 0;
    check("t5_top", pc, 32'hFFFF_FFFC);
    step();
    check("t5_wrap", pc, 32'h0000_0000);
    inst_addr_ok = 0;
    step();
    check("t5_wait_req", inst_req, 1'b1);
    rst = 1;
    #1;
    check("t5_rst_pc", pc, 32'hBFC0_0000);
    check("t5_rst_req", inst_req, 1'b0);
    step();
    rst = 0;
    inst_addr_ok = 1;
    check("t5_state_boot", state_dbg, 2'd0);

    // 6: redirect counting, pending overwrite by priority, stall with direct redirect
    step();
    br_valid = 1; br_target = 32'h8000_0100;
    step();
    br_valid = 0;
    check("t6_br1", pc, 32'h8000_0100);
    inst_addr_ok = 0;
    br_valid = 1; br_target = 32'h8000_0200;
    step();
    br_valid = 0;
    eret_valid = 1; eret_target = 32'h8000_0300;
    step();
    eret_valid = 0;
    br_valid = 1; br_target = 32'h8000_0500;
    step();
    br_valid = 0;
    inst_addr_ok = 1;
    step();
    check("t6_pend_eret", pc, 32'h8000_0300);
    stall = 1;
    #1;
    check("t6_stall_req", inst_req, 1'b0);
    br_valid = 1; br_target = 32'h8000_0400;
    step();
    br_valid = 0;
    check("t6_direct", pc, 32'h8000_0400);
    step();
    check("t6_stall_hold", pc, 32'h8000_0400);
`ifdef PC_REDIRECT_CNT_EN
    check("t6_cnt", redirect_cnt, 32'd3);
`endif
    stall = 0;
    #1;
    check("t6_req_again", inst_req, 1'b1);
    step();
    check("t6_seq", pc, 32'h8000_0404);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch_gen.md
Name: pc_fetch_gen

Overview:
Parametrised next-generation program-counter unit for the fetch stage. It holds the fetch PC and drives an SRAM-like instruction request (req / addr_ok). It arbitrates prioritised redirects (exception, eret, branch) and latches any redirect that arrives while a request is still waiting for acceptance. It also flags misaligned fetch addresses and halts fetch until an exception redirect arrives.

Parameters:
WIDTH, 32, PC width in bits (>= 8).
RESET_VEC, 32'hBFC00000, PC value on reset; truncated to WIDTH.
STEP, 4, sequential increment in bytes.
ALIGN_BITS, 2, low PC bits that must be zero for a legal fetch.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
stall  in  1  downstream stall; blocks issue of new requests
exc_valid  in  1  exception redirect request
exc_target  in  WIDTH  exception vector
eret_valid  in  1  exception-return redirect request
eret_target  in  WIDTH  EPC value
br_valid  in  1  branch/jump redirect request
br_target  in  WIDTH  branch target
inst_req  out  1  instruction fetch request
inst_addr  out  WIDTH  fetch address (current PC)
inst_addr_ok  in  1  memory accepted the address this cycle
pc  out  WIDTH  current PC register
adel  out  1  misaligned-fetch flag (address-error-load)

Behaviour:
- Reset (async, active-high): pc=RESET_VEC, state=BOOT, pend_valid=0, pend_target=0, adel=0, inst_req=0.
- States: BOOT, RUN, ERR.
- BOOT: inst_req=0. Advances unconditionally to RUN on the next clk edge, giving one idle cycle after reset release.
- RUN: inst_req = !stall && !misaligned. misaligned = |pc[ALIGN_BITS-1:0].
- inst_addr = pc at all times. Once inst_req=1 and inst_addr_ok=0, inst_addr must hold stable; stall is ignored until acceptance, so inst_req stays 1.
- Handshake fire = inst_req && inst_addr_ok.
- New-redirect priority in a cycle: exc > eret > br. The selected redirect is sel_valid/sel_target.
- Next-PC selection on fire, in priority order:
  1. sel_valid -> sel_target
  2. pend_valid -> pend_target
  3. otherwise pc+STEP, modulo 2^WIDTH (wraps silently).
- Fire also clears pend_valid.
- No fire and sel_valid=1: pend_target<=sel_target, pend_valid<=1. A later redirect overwrites the pending one only if its priority is >= the pending one's. Pending priority is kept in a 2-bit register.
- No fire and no redirect, but pend_valid=1 and inst_req=0 (stalled, or misaligned and idle): pc<=pend_target and pend_valid<=0 on the next edge. Same-cycle redirects are applied even without fire when inst_req=0.
- Redirect with inst_req=0 and no pending: pc<=sel_target next edge.
- Misaligned pc in RUN with no redirect: adel<=1, state->ERR, inst_req=0. No request is ever issued for a misaligned address.
- ERR: inst_req=0; pc holds.
  - exc_valid=1: pc<=exc_target, adel<=0, state->RUN.
  - eret/br: ignored.
- Reset mid-handshake: all state drops immediately; the outstanding request is abandoned.
- Latency: redirect to first request at the new address = 1 cycle when idle or accepted the same cycle; otherwise the first cycle after acceptance.

Optional Feature:
PC_REDIRECT_CNT_EN.
- Defined: adds output redirect_cnt [31:0], reset 0. It increments by 1 each cycle a redirect is applied to pc, whether direct or from pending, and saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; no other behaviour changes.

Test Plan:
1. Reset release, inst_addr_ok tied 1, no stall -> cycle0 inst_req=0 pc=BFC00000; then addresses BFC00000, BFC00004, BFC00008 on consecutive cycles.
2. inst_req=1 at pc=BFC00010, addr_ok=0 for 3 cycles, br_valid pulse target=80001000 in cycle1 -> inst_addr stays BFC00010 until accepted; next request is 80001000.
3. Same cycle exc_valid target=BFC00380, br_valid target=80002000, fire=1 -> next pc=BFC00380; br discarded.
4. eret_target=80000003 applied -> pc=80000003, adel=1, inst_req=0, state ERR. br_valid ignored. exc_valid target=BFC00380 -> adel=0 and fetch resumes at BFC00380.
5. pc=FFFFFFFC (WIDTH=32), fire -> pc=00000000. Async rst asserted mid-wait -> pc=BFC00000 and inst_req=0 immediately.
6. PC_REDIRECT_CNT_EN defined: 3 applied redirects plus one overwritten pending redirect -> redirect_cnt=3.
